// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target.
package sccb_pkg;

    // Bit counter counts 0..8 within a byte; 9th bit is the ACK slot.
    localparam int                   BIT_CNT_W     = 4;
    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;

    // SDA levels for the acknowledge slot.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } sccb_state_t;

endpackage

// File: rtl/sccb_line_filter.sv
// Two-flop synchronizer followed by a glitch filter. The filtered level only
// follows the pin after FILT_LEN consecutive samples that disagree with it,
// and a one-cycle rise/fall pulse accompanies each filtered change.
module sccb_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_pin,
    output logic O_level,
    output logic O_rise,
    output logic O_fall
);

    localparam int              CNT_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILT_LEN - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize, then down-count disagreeing samples; terminal count commits.
    // Idle bus level is high, so reset parks everything at 1.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= CNT_TC;
        end else begin
            r_sync <= {r_sync[0], I_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= CNT_TC;
            end else if (r_cnt == '0) begin
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
                r_cnt   <= CNT_TC;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign O_level = r_level;
    assign O_rise  = r_rise;
    assign O_fall  = r_fall;

endmodule

// File: rtl/sccb_target.sv
// SCCB target: decodes 3-phase writes and 2-phase write / 2-phase read
// sequences against a 256x8 register file, exposing each committed write.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | bus idle, waiting for START
// ST_ID        | shifting in the device ID byte
// ST_ID_ACK    | driving ACK for a matching ID
// ST_SUB       | shifting in the sub-address byte
// ST_SUB_ACK   | driving ACK for the sub-address
// ST_WDATA     | shifting in the write data byte
// ST_WDATA_ACK | driving ACK, register written on entry
// ST_RDATA     | driving reg[sub_addr] MSB first
// ST_RACK      | SDA released, master's NA bit ignored
// ST_WAIT_STOP | transaction done or not ours; ignore until START/STOP
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID   = 8'h60,
    parameter int         FILT_LEN = 3
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_scl,
    input  logic       I_sda,
    output logic       O_sda_oe,
    output logic       O_wr_en,
    output logic [7:0] O_wr_addr,
    output logic [7:0] O_wr_data,
    output logic       O_busy,
    input  logic [7:0] I_dbg_addr,
    output logic [7:0] O_dbg_data
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_pin   (I_scl),
        .O_level (w_scl_lvl),
        .O_rise  (w_scl_rise),
        .O_fall  (w_scl_fall)
    );

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_pin   (I_sda),
        .O_level (w_sda_lvl),
        .O_rise  (w_sda_rise),
        .O_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    sccb_state_t          r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic [7:0]           r_rd_shift, w_rd_shift_nxt;
    logic [7:0]           r_sub_addr, w_sub_addr_nxt;
    logic                 r_sda_oe, w_sda_oe_nxt;
    logic                 r_wr_en, w_wr_en_nxt;
    logic [7:0]           r_wr_addr, w_wr_addr_nxt;
    logic [7:0]           r_wr_data, w_wr_data_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 w_mem_we;
    logic [7:0]           w_mem_rd;
    logic [7:0]           r_dbg_data;
    logic [7:0]           r_mem [0:255];

    logic w_byte_done;
    logic w_id_match;

    assign w_mem_rd    = r_mem[r_sub_addr];
    assign w_byte_done = (r_bit_cnt == BITS_PER_BYTE);
    assign w_id_match  = (r_shift[7:1] == DEV_ID[7:1]);

    // State and datapath registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rd_shift <= '0;
            r_sub_addr <= '0;
            r_sda_oe   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rd_shift <= w_rd_shift_nxt;
            r_sub_addr <= w_sub_addr_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state and output decode. Bits are counted on SCL rise; all SDA
    // drive changes happen on SCL fall so they land while SCL is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rd_shift_nxt = r_rd_shift;
        w_sub_addr_nxt = r_sub_addr;
        w_sda_oe_nxt   = r_sda_oe;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_busy_nxt     = r_busy;
        w_mem_we       = 1'b0;

        if (w_start) begin
            w_state_nxt   = ST_ID;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = ~NACK;
            w_busy_nxt    = 1'b1;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = ~NACK;
            w_busy_nxt    = 1'b0;
        end else begin
            if (w_scl_rise && !w_byte_done &&
                (r_state inside {ST_ID, ST_SUB, ST_WDATA, ST_RDATA})) begin
                w_shift_nxt   = {r_shift[6:0], w_sda_lvl};
                w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
            if (w_scl_fall) begin
                case (r_state)
                    ST_ID: begin
                        if (w_byte_done) begin
                            if (w_id_match) begin
                                w_state_nxt  = ST_ID_ACK;
                                w_sda_oe_nxt = ~ACK;
                            end else begin
                                w_state_nxt  = ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ID_ACK: begin
                        w_bit_cnt_nxt = '0;
                        if (r_shift[0]) begin
                            // Present the first read bit as soon as ACK ends.
                            w_state_nxt    = ST_RDATA;
                            w_rd_shift_nxt = w_mem_rd;
                            w_sda_oe_nxt   = ~w_mem_rd[7];
                        end else begin
                            w_state_nxt  = ST_SUB;
                            w_sda_oe_nxt = ~NACK;
                        end
                    end
                    ST_SUB: begin
                        if (w_byte_done) begin
                            w_state_nxt    = ST_SUB_ACK;
                            w_sub_addr_nxt = r_shift;
                            w_sda_oe_nxt   = ~ACK;
                        end
                    end
                    ST_SUB_ACK: begin
                        w_state_nxt   = ST_WDATA;
                        w_bit_cnt_nxt = '0;
                        w_sda_oe_nxt  = ~NACK;
                    end
                    ST_WDATA: begin
                        if (w_byte_done) begin
                            w_state_nxt   = ST_WDATA_ACK;
                            w_sda_oe_nxt  = ~ACK;
                            w_mem_we      = 1'b1;
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = r_sub_addr;
                            w_wr_data_nxt = r_shift;
                        end
                    end
                    ST_WDATA_ACK: begin
                        w_state_nxt  = ST_WAIT_STOP;
                        w_sda_oe_nxt = ~NACK;
                    end
                    ST_RDATA: begin
                        if (w_byte_done) begin
                            w_state_nxt  = ST_RACK;
                            w_sda_oe_nxt = ~NACK;
                        end else if (r_bit_cnt != '0) begin
                            w_rd_shift_nxt = {r_rd_shift[6:0], 1'b0};
                            w_sda_oe_nxt   = ~r_rd_shift[6];
                        end
                    end
                    ST_RACK: begin
                        w_state_nxt  = ST_WAIT_STOP;
                        w_sda_oe_nxt = ~NACK;
                    end
                    default: begin
                        w_sda_oe_nxt = ~NACK;
                    end
                endcase
            end
        end
    end

    // Register file write port; contents survive reset, but a write never
    // commits in a reset cycle.
    always_ff @(posedge I_clk) begin
        if (w_mem_we && !I_rst) begin
            r_mem[r_sub_addr] <= r_shift;
        end
    end

    // Debug read port, read-before-write on address collision.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[I_dbg_addr];
        end
    end

    assign O_sda_oe   = r_sda_oe;
    assign O_wr_en    = r_wr_en;
    assign O_wr_addr  = r_wr_addr;
    assign O_wr_data  = r_wr_data;
    assign O_busy     = r_busy;
    assign O_dbg_data = r_dbg_data;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a bit-banged SCCB master on an open-drain
// SDA line, with a negedge monitor tracking write pulses and drive activity.
module tb_sccb_target;

    localparam int Q = 8;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_scl;
    logic       tb_sda;
    logic [7:0] dbg_addr;
    logic       w_sda_pin;

    logic       O_sda_oe;
    logic       O_wr_en;
    logic [7:0] O_wr_addr;
    logic [7:0] O_wr_data;
    logic       O_busy;
    logic [7:0] O_dbg_data;

    int tests = 0;
    int fails = 0;

    int         wr_cnt      = 0;
    int         oe_hi_cnt   = 0;
    int         busy_hi_cnt = 0;
    logic [7:0] mon_addr    = 8'h00;
    logic [7:0] mon_data    = 8'h00;
    logic       mon_wr_oe   = 1'b0;
    logic       prev_oe     = 1'b0;

    always #5 clk = ~clk;

    assign w_sda_pin = tb_sda & ~O_sda_oe;

    sccb_target #(.DEV_ID(8'h60), .FILT_LEN(3)) dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_scl      (tb_scl),
        .I_sda      (w_sda_pin),
        .O_sda_oe   (O_sda_oe),
        .O_wr_en    (O_wr_en),
        .O_wr_addr  (O_wr_addr),
        .O_wr_data  (O_wr_data),
        .O_busy     (O_busy),
        .I_dbg_addr (dbg_addr),
        .O_dbg_data (O_dbg_data)
    );

    // Observe outputs mid-cycle.
    always @(negedge clk) begin
        if (O_wr_en) begin
            wr_cnt    = wr_cnt + 1;
            mon_addr  = O_wr_addr;
            mon_data  = O_wr_data;
            mon_wr_oe = O_sda_oe && !prev_oe;
        end
        if (O_sda_oe) oe_hi_cnt = oe_hi_cnt + 1;
        if (O_busy) busy_hi_cnt = busy_hi_cnt + 1;
        prev_oe = O_sda_oe;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sccb_start();
        tb_sda = 1'b1; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tb_sda = 1'b0; wait_clk(Q);
        tb_scl = 1'b0;
    endtask

    task automatic sccb_stop();
        wait_clk(Q);
        tb_sda = 1'b0; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tb_sda = 1'b1; wait_clk(Q);
    endtask

    // One SCL period, entered and left with SCL low.
    task automatic bit_slot(input logic b, output logic pin_hi, output logic oe_hi);
        wait_clk(Q);
        tb_sda = b;
        wait_clk(Q);
        tb_scl = 1'b1;
        wait_clk(Q);
        pin_hi = w_sda_pin;
        oe_hi  = O_sda_oe;
        wait_clk(Q);
        tb_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_pin);
        logic p, o;
        for (int i = 7; i >= 0; i--) bit_slot(d[i], p, o);
        bit_slot(1'b1, ack_pin, o);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic oe_9th);
        logic p, o;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, p, o);
            d[i] = p;
        end
        bit_slot(1'b1, p, oe_9th);
    endtask

    task automatic test_reset();
        rst = 1'b1; tb_scl = 1'b1; tb_sda = 1'b1; dbg_addr = 8'h00;
        wait_clk(5);
        tests++; if (O_sda_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", O_sda_oe); end
        tests++; if (O_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", O_wr_en); end
        tests++; if (O_wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr: got %h want 00", O_wr_addr); end
        tests++; if (O_wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data: got %h want 00", O_wr_data); end
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", O_busy); end
        tests++; if (O_dbg_data !== 8'h00) begin fails++; $display("FAIL reset_dbg: got %h want 00", O_dbg_data); end
        rst = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int   w0;
        w0 = wr_cnt;
        sccb_start();
        send_byte(8'h60, a0);
        send_byte(8'h12, a1);
        tests++; if (O_busy !== 1'b1) begin fails++; $display("FAIL write_busy_mid: got %b want 1", O_busy); end
        send_byte(8'h80, a2);
        sccb_stop();
        wait_clk(4);
        tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL write_pulses: got %0d want 1", wr_cnt - w0); end
        tests++; if (mon_addr !== 8'h12) begin fails++; $display("FAIL write_addr: got %h want 12", mon_addr); end
        tests++; if (mon_data !== 8'h80) begin fails++; $display("FAIL write_data: got %h want 80", mon_data); end
        tests++; if (mon_wr_oe !== 1'b1) begin fails++; $display("FAIL write_en_with_ack: got %b want 1", mon_wr_oe); end
        tests++; if (O_wr_addr !== 8'h12 || O_wr_data !== 8'h80) begin fails++; $display("FAIL write_hold: got %h/%h want 12/80", O_wr_addr, O_wr_data); end
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL write_busy_end: got %b want 0", O_busy); end
        dbg_addr = 8'h12;
        wait_clk(2);
        tests++; if (O_dbg_data !== 8'h80) begin fails++; $display("FAIL write_dbg: got %h want 80", O_dbg_data); end
    endtask

    task automatic test_read();
        logic       a0, a1, a2, a3, a4, oe9;
        logic [7:0] d;
        int         w0;
        w0 = wr_cnt;
        sccb_start();
        send_byte(8'h60, a0); send_byte(8'hFF, a1); send_byte(8'h01, a2);
        sccb_stop();
        sccb_start();
        send_byte(8'h60, a3); send_byte(8'hFF, a4);
        sccb_stop();
        wait_clk(4);
        tests++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin fails++; $display("FAIL read_setup_acks: got %b want 00000", {a0, a1, a2, a3, a4}); end
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL read_setup_pulses: got %0d want 1", wr_cnt - w0); end
        sccb_start();
        send_byte(8'h61, a0);
        tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL read_id_ack: got %b want 0", a0); end
        read_byte(d, oe9);
        tests++; if (d !== 8'h01) begin fails++; $display("FAIL read_data: got %h want 01", d); end
        tests++; if (oe9 !== 1'b0) begin fails++; $display("FAIL read_9th_release: got %b want 0", oe9); end
        tests++; if (O_busy !== 1'b1) begin fails++; $display("FAIL read_busy_mid: got %b want 1", O_busy); end
        sccb_stop();
        wait_clk(4);
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL read_busy_end: got %b want 0", O_busy); end
    endtask

    task automatic test_wrong_id();
        logic a0, a1, a2;
        int   w0;
        w0 = wr_cnt;
        oe_hi_cnt = 0;
        sccb_start();
        send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
        sccb_stop();
        wait_clk(4);
        tests++; if (oe_hi_cnt != 0) begin fails++; $display("FAIL wrongid_oe: got %0d cycles want 0", oe_hi_cnt); end
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL wrongid_pulses: got %0d want 0", wr_cnt - w0); end
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL wrongid_acks: got %b want 111", {a0, a1, a2}); end
    endtask

    task automatic test_glitch();
        busy_hi_cnt = 0;
        tb_scl = 1'b1; tb_sda = 1'b1;
        wait_clk(10);
        tb_sda = 1'b0; wait_clk(1); tb_sda = 1'b1;
        wait_clk(20);
        tb_sda = 1'b0; wait_clk(2); tb_sda = 1'b1;
        wait_clk(20);
        tests++; if (busy_hi_cnt != 0) begin fails++; $display("FAIL glitch_busy: got %0d cycles want 0", busy_hi_cnt); end
        tb_sda = 1'b0; wait_clk(Q);
        tests++; if (O_busy !== 1'b1) begin fails++; $display("FAIL glitch_real_start: got %b want 1", O_busy); end
        tb_sda = 1'b1; wait_clk(Q);
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL glitch_real_stop: got %b want 0", O_busy); end
    endtask

    task automatic test_abort();
        logic a0, a1, p, o;
        logic [2:0] acks;
        int   w0;
        w0 = wr_cnt;
        sccb_start();
        send_byte(8'h60, a0); send_byte(8'h34, a1);
        bit_slot(1'b1, p, o); bit_slot(1'b0, p, o); bit_slot(1'b1, p, o); bit_slot(1'b0, p, o);
        sccb_stop();
        wait_clk(4);
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL abort_pulses: got %0d want 0", wr_cnt - w0); end
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", O_busy); end
        sccb_start();
        send_byte(8'h60, acks[2]); send_byte(8'h34, acks[1]); send_byte(8'h5A, acks[0]);
        sccb_stop();
        wait_clk(4);
        tests++; if (acks !== 3'b000) begin fails++; $display("FAIL abort_retry_acks: got %b want 000", acks); end
        tests++; if (wr_cnt - w0 != 1) begin fails++; $display("FAIL abort_retry_pulses: got %0d want 1", wr_cnt - w0); end
        tests++; if (mon_addr !== 8'h34 || mon_data !== 8'h5A) begin fails++; $display("FAIL abort_retry_write: got %h/%h want 34/5a", mon_addr, mon_data); end
        dbg_addr = 8'h34;
        wait_clk(2);
        tests++; if (O_dbg_data !== 8'h5A) begin fails++; $display("FAIL abort_dbg: got %h want 5a", O_dbg_data); end
    endtask

    task automatic test_reset_mid();
        logic a0, a1, a2, p, o;
        int   w0;
        w0 = wr_cnt;
        sccb_start();
        send_byte(8'h60, a0); send_byte(8'h12, a1);
        sccb_stop();
        sccb_start();
        send_byte(8'h61, a2);
        for (int i = 0; i < 7; i++) bit_slot(1'b1, p, o);
        wait_clk(Q);
        wait_clk(Q);
        tests++; if (O_sda_oe !== 1'b1) begin fails++; $display("FAIL rstmid_bit0_drive: got %b want 1", O_sda_oe); end
        rst = 1'b1;
        wait_clk(1);
        tests++; if (O_sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b want 0", O_sda_oe); end
        tests++; if (O_busy !== 1'b0 || O_wr_en !== 1'b0) begin fails++; $display("FAIL rstmid_busy_wren: got %b/%b want 0/0", O_busy, O_wr_en); end
        tests++; if (O_wr_addr !== 8'h00 || O_wr_data !== 8'h00) begin fails++; $display("FAIL rstmid_wr_regs: got %h/%h want 00/00", O_wr_addr, O_wr_data); end
        tests++; if (O_dbg_data !== 8'h00) begin fails++; $display("FAIL rstmid_dbg: got %h want 00", O_dbg_data); end
        wait_clk(3);
        rst = 1'b0;
        tb_sda = 1'b1; wait_clk(Q);
        tb_scl = 1'b1; wait_clk(Q);
        tests++; if (O_busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got %b want 0", O_busy); end
        dbg_addr = 8'h12;
        wait_clk(2);
        tests++; if (O_dbg_data !== 8'h80) begin fails++; $display("FAIL rstmid_mem_kept: got %h want 80", O_dbg_data); end
        tests++; if (wr_cnt - w0 != 0) begin fails++; $display("FAIL rstmid_pulses: got %0d want 0", wr_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_id();
        test_glitch();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
